// File: rtl/disp_share_arbiter.sv
// rtl/disp_share_arbiter.sv - round-robin owner arbiter for the shared 7-segment display
module disp_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int IW    = 2,
    parameter int DWELL = 50_000_000,
    parameter int CW    = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*32-1:0] data,
    input  logic              hold,
    output logic [NREQ-1:0]   grant,
    output logic [IW-1:0]     owner,
    output logic              active,
    output logic [31:0]       num_out
);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic [NREQ-1:0] grant_d;
    logic [IW-1:0]   owner_d;
    logic            active_d;
    logic [31:0]     num_d;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_onehot;
    logic [31:0]     owner_data;

    // Round-robin search starting just after the last owner; the last owner itself is tried last
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_q) + k) % NREQ;
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(idx);
            end
        end
    end

    assign pick_onehot = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
    assign owner_data  = data[int'(owner) * 32 +: 32];

    // Next-state and next-output decisions; every register holds unless told otherwise
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        grant_d  = grant;
        owner_d  = owner;
        active_d = active;
        num_d    = num_out;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d  = SHOW;
                    grant_d  = pick_onehot;
                    owner_d  = pick_idx;
                    last_d   = pick_idx;
                    cnt_d    = '0;
                    active_d = 1'b1;
                end
            end
            SHOW: begin
                num_d = owner_data;
                if (!req[owner]) begin
                    // Owner let go: hand over immediately, ignoring hold and dwell
                    if (pick_found) begin
                        grant_d = pick_onehot;
                        owner_d = pick_idx;
                        last_d  = pick_idx;
                        cnt_d   = '0;
                    end else begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        active_d = 1'b0;
                    end
                end else if (!hold) begin
                    if (cnt_q == CW'(DWELL - 1)) begin
                        cnt_d = '0;
                        // last equals owner here, so a pick of the owner means nobody else waits
                        if (pick_idx != owner) begin
                            grant_d = pick_onehot;
                            owner_d = pick_idx;
                            last_d  = pick_idx;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            grant   <= '0;
            owner   <= '0;
            active  <= 1'b0;
            num_out <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant   <= grant_d;
            owner   <= owner_d;
            active  <= active_d;
            num_out <= num_d;
        end
    end

endmodule

// File: tb/tb_disp_share_arbiter.sv
// tb/tb_disp_share_arbiter.sv - directed self-checking bench for disp_share_arbiter
module tb_disp_share_arbiter;

    localparam int NREQ = 4;
    localparam int IW   = 2;

    localparam logic [31:0] D0 = 32'h1111_1111;
    localparam logic [31:0] D1 = 32'h3333_3333;
    localparam logic [31:0] D2 = 32'h2222_2222;
    localparam logic [31:0] D3 = 32'h4444_4444;
    localparam logic [31:0] D0B = 32'h5555_5555;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*32-1:0] data;
    logic              hold;
    logic [NREQ-1:0]   grant;
    logic [IW-1:0]     owner;
    logic              active;
    logic [31:0]       num_out;

    int compared   = 0;
    int mismatched = 0;

    disp_share_arbiter #(
        .NREQ(NREQ), .IW(IW), .DWELL(4), .CW(3)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .hold(hold),
        .grant(grant), .owner(owner), .active(active), .num_out(num_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int eo;
        int po;
        rst  = 1'b1;
        req  = '0;
        hold = 1'b0;
        data = {D3, D2, D1, D0};

        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_num", num_out, 32'h0);

        rst = 1'b0;
        req = 4'b0101;
        tick();
        chk("first_grant", 32'(grant), 32'h1);
        chk("first_owner", 32'(owner), 32'h0);
        chk("first_active", 32'(active), 32'h1);

        // Rotation 0,2,0,2,...; num_out lags the owner by one edge
        for (int t = 1; t <= 21; t++) begin
            tick();
            eo = (((t / 4) % 2) == 1) ? 2 : 0;
            po = ((((t - 1) / 4) % 2) == 1) ? 2 : 0;
            chk($sformatf("rot_grant_t%0d", t), 32'(grant), 32'(1) << eo);
            chk($sformatf("rot_owner_t%0d", t), 32'(owner), 32'(eo));
            chk($sformatf("rot_num_t%0d", t), num_out, (po == 2) ? D2 : D0);
        end

        // Owner 2 at cnt=1 drops out with nobody else waiting
        req = 4'b0000;
        tick();
        chk("rel_grant", 32'(grant), 32'h0);
        chk("rel_active", 32'(active), 32'h0);
        chk("rel_num", num_out, D2);
        chk("rel_owner", 32'(owner), 32'h2);

        req = 4'b0010;
        tick();
        chk("wrap_grant", 32'(grant), 32'h2);
        chk("wrap_owner", 32'(owner), 32'h1);
        tick();
        chk("wrap_num", num_out, D1);

        // Owner 1 releases; search 2,3,0 finds 0
        req = 4'b0001;
        tick();
        chk("h_start_grant", 32'(grant), 32'h1);

        req  = 4'b0011;
        hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("hold_grant_%0d", i), 32'(grant), 32'h1);
        end
        hold = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("unhold_grant_%0d", i), 32'(grant), 32'h1);
        end
        tick();
        chk("unhold_switch_grant", 32'(grant), 32'h2);
        chk("unhold_switch_owner", 32'(owner), 32'h1);

        // Sole requester 3
        req = 4'b1000;
        tick();
        chk("sole_first_grant", 32'(grant), 32'h8);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("sole_grant_%0d", i), 32'(grant), 32'h8);
            chk($sformatf("sole_active_%0d", i), 32'(active), 32'h1);
        end
        tick();
        tick();
        chk("sole_owner", 32'(owner), 32'h3);

        // Reset in SHOW with owner 3, cnt 2
        rst = 1'b1;
        req = 4'b1111;
        tick();
        chk("mrst_grant", 32'(grant), 32'h0);
        chk("mrst_owner", 32'(owner), 32'h0);
        chk("mrst_active", 32'(active), 32'h0);
        chk("mrst_num", num_out, 32'h0);

        rst = 1'b0;
        tick();
        chk("post_grant", 32'(grant), 32'h1);
        chk("post_owner", 32'(owner), 32'h0);
        tick();
        chk("post_num", num_out, D0);

        data[31:0] = D0B;
        tick();
        chk("data_change_num", num_out, D0B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
